// File: rtl/sample_select_v_if.sv
// Handshake/data bundle between a residual producer and the digit selector.
interface sample_select_v_if #(
   parameter int W           = 9,
   parameter int SAMPLE_BITS = 3,
   parameter int CW          = 3
);
   logic                   start;
   logic                   in_valid;
   logic [W-1:0]           positive_vec;
   logic [W-1:0]           negative_vec;
   logic [SAMPLE_BITS-1:0] sample_out;
   logic                   digit_pos;
   logic                   digit_neg;
   logic                   out_valid;
   logic                   busy;
   logic                   done;
   logic [CW-1:0]          iter_cnt;

   modport master (
      output start, in_valid, positive_vec, negative_vec,
      input  sample_out, digit_pos, digit_neg, out_valid, busy, done, iter_cnt
   );

   modport slave (
      input  start, in_valid, positive_vec, negative_vec,
      output sample_out, digit_pos, digit_neg, out_valid, busy, done, iter_cnt
   );
endinterface

// File: rtl/sample_select_v.sv
// Online-arithmetic digit selector: samples the residual MSBs and picks a
// signed digit {-1,0,+1} per accepted beat, over a sequence of N digits.
//
// state | meaning
// IDLE  | waiting for start; in_valid ignored
// RUN   | accepting up to N residual beats
// DRAIN | last beat sits in the input stage (REG_IN=1 only); no new input
module sample_select_v #(
   parameter int NUM_BITS      = 4,
   parameter int ON_LINE_DELAY = 3,
   parameter int SAMPLE_BITS   = 3,
   parameter int REG_IN        = 0
) (
   input logic             clk,
   input logic             rst,
   sample_select_v_if.slave bus
);
   localparam int W  = NUM_BITS + ON_LINE_DELAY + 2;
   localparam int N  = NUM_BITS + ON_LINE_DELAY;
   localparam int CW = $clog2(N + 1);

   localparam int T_INT = 2 ** (SAMPLE_BITS - 3);
   localparam logic signed [SAMPLE_BITS-1:0] T_POS = SAMPLE_BITS'(T_INT);
   localparam logic signed [SAMPLE_BITS-1:0] T_NEG = SAMPLE_BITS'(-T_INT);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic                    accept;
   logic [CW-1:0]           in_cnt;
   logic [W-1:0]            v_in;
   logic                    pipe_valid;
   logic [W-1:0]            pipe_v;
   logic signed [SAMPLE_BITS-1:0] s_pipe;

   logic [SAMPLE_BITS-1:0]  sample_r;
   logic                    digit_pos_r;
   logic                    digit_neg_r;
   logic                    out_valid_r;
   logic                    done_r;
   logic [CW-1:0]           iter_cnt_r;

   assign v_in = bus.positive_vec - bus.negative_vec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = RUN;
         end
         RUN: begin
            accept = bus.in_valid && !bus.start && (in_cnt < CW'(N));
            if (bus.start)
               state_nxt = RUN;
            else if (done_r)
               state_nxt = IDLE;
            else if ((REG_IN != 0) && accept && (in_cnt == CW'(N - 1)))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (bus.start)   state_nxt = RUN;
            else if (done_r) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            in_cnt <= '0;
      else if (bus.start) in_cnt <= '0;
      else if (accept)    in_cnt <= in_cnt + 1'b1;
   end

   generate
      if (REG_IN != 0) begin : g_reg_in
         logic          stage_valid;
         logic [W-1:0]  stage_v;

         // start flushes the stage so an in-flight beat never reaches the output
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               stage_valid <= 1'b0;
               stage_v     <= '0;
            end else if (bus.start) begin
               stage_valid <= 1'b0;
               stage_v     <= '0;
            end else begin
               stage_valid <= accept;
               if (accept) stage_v <= v_in;
            end
         end

         assign pipe_valid = stage_valid;
         assign pipe_v     = stage_v;
      end else begin : g_no_reg
         assign pipe_valid = accept;
         assign pipe_v     = v_in;
      end
   endgenerate

   assign s_pipe = pipe_v[W-1 -: SAMPLE_BITS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_r    <= '0;
         digit_pos_r <= 1'b0;
         digit_neg_r <= 1'b0;
         out_valid_r <= 1'b0;
         done_r      <= 1'b0;
         iter_cnt_r  <= '0;
      end else if (bus.start) begin
         out_valid_r <= 1'b0;
         done_r      <= 1'b0;
         iter_cnt_r  <= '0;
      end else if (pipe_valid) begin
         sample_r    <= s_pipe;
         digit_pos_r <= (s_pipe >= T_POS);
         digit_neg_r <= (s_pipe < T_NEG);
         out_valid_r <= 1'b1;
         done_r      <= (iter_cnt_r == CW'(N - 1));
         if (iter_cnt_r != CW'(N)) iter_cnt_r <= iter_cnt_r + 1'b1;
      end else begin
         out_valid_r <= 1'b0;
         done_r      <= 1'b0;
      end
   end

   assign bus.sample_out = sample_r;
   assign bus.digit_pos  = digit_pos_r;
   assign bus.digit_neg  = digit_neg_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.done       = done_r;
   assign bus.iter_cnt   = iter_cnt_r;
   assign bus.busy       = (state != IDLE);
endmodule

// File: doc/sample_select_v.md
SAMPLE_SELECT_V -- requirements
Module: sample_select_v

Interface
REQ-001 SHALL have parameter NUM_BITS, default 4: operand digit count.
REQ-002 SHALL have parameter ON_LINE_DELAY, default 3: online delay in digits.
REQ-003 SHALL have parameter SAMPLE_BITS, default 3, legal range 3..W: number of residual MSBs sampled.
REQ-004 SHALL have parameter REG_IN, default 0: 1 adds an input register stage.
REQ-005 SHALL define the derived widths W = NUM_BITS+ON_LINE_DELAY+2, N = NUM_BITS+ON_LINE_DELAY and CW = clog2(N+1).
REQ-006 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port start, input, 1: begin a new digit sequence.
REQ-009 SHALL have port in_valid, input, 1: residual vectors valid this cycle.
REQ-010 SHALL have ports positive_vec and negative_vec, input, W each: redundant residual, V = positive_vec - negative_vec.
REQ-011 SHALL have port sample_out, output, SAMPLE_BITS: registered V[W-1:W-SAMPLE_BITS].
REQ-012 SHALL have ports digit_pos and digit_neg, output, 1 each: selected digit, where +1=10, -1=01, 0=00.
REQ-013 SHALL have port out_valid, output, 1: sample_out and the digit outputs are valid.
REQ-014 SHALL have port busy, output, 1: high when the FSM is not in IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse with the last digit.
REQ-016 SHALL have port iter_cnt, output, CW: number of digits emitted in the current sequence.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DRAIN; DRAIN is used only when REG_IN=1.
REQ-018 SHALL move from IDLE to RUN on start, clearing iter_cnt and the input stage.
REQ-019 SHALL ignore in_valid while in IDLE; no outputs change except out_valid=0.
REQ-020 SHALL, in RUN, accept each in_valid cycle by computing V = positive_vec - negative_vec modulo 2^W.
REQ-021 SHALL treat s = V[W-1:W-SAMPLE_BITS] as a two's-complement integer and set T = 2^(SAMPLE_BITS-3).
REQ-022 SHALL select digit +1 when s >= T, -1 when s < -T, and 0 otherwise; digit_pos and digit_neg are never both 1.
REQ-023 SHALL register out_valid, sample_out and the digits 1 cycle after an accepted in_valid when REG_IN=0, or 2 cycles after when REG_IN=1.
REQ-024 SHALL hold sample_out and the digits between valid outputs and drive out_valid=0 on cycles without a result.
REQ-025 SHALL increment iter_cnt with every out_valid, saturating at N.
REQ-026 SHALL pulse done together with the Nth out_valid, then enter IDLE; if REG_IN=1 and the Nth input is accepted, it enters DRAIN first, ignores further in_valid, and goes to IDLE on the done cycle.
REQ-027 SHALL ignore in_valid beyond the Nth in a sequence.
REQ-028 SHALL, when start is asserted in RUN or DRAIN, restart: iter_cnt=0, in-flight pipeline data is discarded (no out_valid for it), and in_valid in the same cycle is ignored.
REQ-029 SHALL, when start coincides with the done cycle, pulse done for the old sequence and begin a new sequence in RUN.

Reset
REQ-030 SHALL, while rst=1 at any time, asynchronously force state IDLE, sample_out=0, digit_pos=0, digit_neg=0, out_valid=0, busy=0, done=0, iter_cnt=0 and clear the input stage.
REQ-031 SHALL require a start after rst deasserts before any further in_valid is accepted; rst asserted mid-sequence aborts it with no done.

Verification (NUM_BITS=4, ON_LINE_DELAY=3, SAMPLE_BITS=3, so W=9, T=1)
REQ-032 SHALL cover: start, then pos=9'h040, neg=0 -> next cycle out_valid=1, sample_out=3'b001, digit=+1 (10), iter_cnt=1.
REQ-033 SHALL cover: pos=0, neg=9'h080 -> sample_out=3'b110, digit=-1 (01); and pos=0, neg=9'h040 -> sample_out=3'b111, digit=0 (00).
REQ-034 SHALL cover: 7 consecutive in_valid beats -> 7 out_valid, done pulses with the 7th, busy drops the next cycle, and an 8th in_valid produces no output.
REQ-035 SHALL cover: REG_IN=1 with the same stimulus as REQ-032 -> out_valid 2 cycles after in_valid, and the values are unchanged.
REQ-036 SHALL cover: start asserted after 3 digits -> iter_cnt=0, no stale out_valid, and a full 7-digit sequence follows with done.
REQ-037 SHALL cover: rst pulsed mid-RUN, asynchronously between clock edges -> all outputs 0 immediately, no done, and in_valid ignored until the next start.
